// File: rtl/nds_async_buff_pkg.sv
// nds_async_buff_pkg: shared FSM encoding and limits for the nds_async_buff
// write/read schedulers.
package nds_async_buff_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_e;

   localparam int MAX_REQ = 8;

endpackage

// File: rtl/nds_rr_pick.sv
// nds_rr_pick: combinational round-robin picker; first set req bit at or after
// rr_ptr_i, wrapping modulo NUM_REQ. Shared by the buffer's write and read sides.
module nds_rr_pick #(
   parameter int  NUM_REQ = 4,
   localparam int IW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IW-1:0]      rr_ptr_i,
   output logic [NUM_REQ-1:0] win_o,
   output logic [IW-1:0]      win_idx_o,
   output logic               valid_o
);

   // Scan downwards so the candidate closest to rr_ptr_i is written last.
   always_comb begin
      logic [IW-1:0] idx;
      idx       = '0;
      win_idx_o = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = IW'((int'(rr_ptr_i) + k) % NUM_REQ);
         if (req_i[idx]) win_idx_o = idx;
      end
   end

   assign valid_o = |req_i;
   assign win_o   = valid_o ? NUM_REQ'(1) << win_idx_o : '0;

endmodule

// File: rtl/nds_async_buff_wr_arb.sv
// nds_async_buff_wr_arb: round-robin write scheduler for the single-entry nds_async_buff.
// Optional burst lock (req_lock_i) is built when NDS_ASYNC_BUFF_WR_ARB_LOCK_EN is defined.
module nds_async_buff_wr_arb
   import nds_async_buff_pkg::*;
#(
   parameter int  NUM_REQ    = 4,
   parameter int  DATA_WIDTH = 32,
   localparam int IW         = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NUM_REQ-1:0]            req_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
`ifdef NDS_ASYNC_BUFF_WR_ARB_LOCK_EN
   input  logic [NUM_REQ-1:0]            req_lock_i,
`endif
   output logic [NUM_REQ-1:0]            gnt_o,
   output logic                          buf_wr_o,
   output logic [DATA_WIDTH-1:0]         buf_wr_data_o,
   input  logic                          buf_full_i,
   output logic [IW-1:0]                 gnt_id_o
);

   state_e                state_q, state_d;
   logic [IW-1:0]         rr_ptr_q, rr_ptr_d, gnt_id_q, gnt_id_d, pick_idx, win_idx;
   logic [NUM_REQ-1:0]    gnt_q, gnt_d, pick_oh, win_oh;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  buf_wr_q, buf_wr_d, pick_valid, held;

   nds_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req_i     (req_i),
      .rr_ptr_i  (rr_ptr_q),
      .win_o     (pick_oh),
      .win_idx_o (pick_idx),
      .valid_o   (pick_valid)
   );

`ifdef NDS_ASYNC_BUFF_WR_ARB_LOCK_EN
   logic          lock_q, lock_d;
   logic [IW-1:0] lock_id_q, lock_id_d;

   assign held    = lock_q && req_i[lock_id_q] && req_lock_i[lock_id_q];
   assign win_idx = held ? lock_id_q : pick_idx;
   assign win_oh  = held ? NUM_REQ'(1) << lock_id_q : pick_oh;

   // The lock is re-evaluated only at IDLE arbitration points.
   always_comb begin
      lock_d    = lock_q;
      lock_id_d = lock_id_q;
      if (state_q == IDLE && !buf_full_i) begin
         lock_d    = pick_valid && req_lock_i[win_idx];
         lock_id_d = win_idx;
      end
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         lock_q    <= 1'b0;
         lock_id_q <= '0;
      end else begin
         lock_q    <= lock_d;
         lock_id_q <= lock_id_d;
      end
`else
   assign held    = 1'b0;
   assign win_idx = pick_idx;
   assign win_oh  = pick_oh;
`endif

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      gnt_id_d = gnt_id_q;
      data_d   = data_q;
      gnt_d    = '0;
      buf_wr_d = 1'b0;
      case (state_q)
         IDLE: if (pick_valid && !buf_full_i) begin
            state_d  = ISSUE;
            buf_wr_d = 1'b1;
            gnt_d    = win_oh;
            gnt_id_d = win_idx;
            data_d   = req_data_i[win_idx*DATA_WIDTH +: DATA_WIDTH];
            rr_ptr_d = held ? rr_ptr_q : (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);
         end
         // full only rises the cycle after wr, so never arbitrate here
         ISSUE: state_d = WAIT;
         WAIT:  if (!buf_full_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         gnt_id_q <= '0;
         data_q   <= '0;
         gnt_q    <= '0;
         buf_wr_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         gnt_id_q <= gnt_id_d;
         data_q   <= data_d;
         gnt_q    <= gnt_d;
         buf_wr_q <= buf_wr_d;
      end

   assign gnt_o         = gnt_q;
   assign buf_wr_o      = buf_wr_q;
   assign buf_wr_data_o = data_q;
   assign gnt_id_o      = gnt_id_q;

endmodule

// File: doc/nds_async_buff_wr_arb.md
# nds_async_buff_wr_arb

- Write-side scheduler for the single-entry clock-crossing buffer (`nds_async_buff`).
- Shares the buffer's write port among `NUM_REQ` requesters in the write clock domain using round-robin arbitration.
- Drives the buffer's `wr`/`wr_data` from a registered stage and observes its `full`.
- Returns a one-cycle grant to the requester whose word was written.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_WIDTH`, 32: word width; must match the buffer instance.
- `clk` input 1: write-domain clock; the block's only clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `req` input `NUM_REQ`: level request per requester; held until the matching `gnt`.
- `req_data` input `NUM_REQ*DATA_WIDTH`: requester i's word is in bits `[i*DATA_WIDTH +: DATA_WIDTH]`; stable while `req[i]` is high.
- `req_lock` input `NUM_REQ`: burst lock; present only with the macro (see Configuration).
- `gnt` output `NUM_REQ`: one-hot, one-cycle pulse; the word was written this cycle.
- `buf_wr` output 1: registered write strobe to the buffer `wr`.
- `buf_wr_data` output `DATA_WIDTH`: registered data to the buffer `wr_data`.
- `buf_full` input 1: buffer `full`.
- `gnt_id` output `$clog2(NUM_REQ)`: index of the last granted requester; held between grants.

## Operation
- FSM states:
  - IDLE: reset state.
  - ISSUE: `buf_wr` high for exactly one cycle.
  - WAIT: waits for the buffer to drain.
- IDLE → ISSUE:
  - Condition: `|req && !buf_full` at a clock edge.
  - Winner = first set `req` bit at or after `rr_ptr`, wrapping modulo `NUM_REQ`.
  - At that edge: `buf_wr_data` ← winner's word; `buf_wr`=1; `gnt[winner]`=1; `gnt_id`=winner; `rr_ptr` ← winner+1 mod `NUM_REQ`.
- ISSUE → WAIT, unconditionally.
  - The buffer's `full` rises only the cycle after `wr`, so the block never arbitrates in the ISSUE cycle.
- WAIT → IDLE when `buf_full`=0. Arbitration happens in IDLE, not in the WAIT exit cycle.
- Throughput: at most one word per 3 cycles plus the read-side drain time.
- Requester rules:
  - The requester drops `req` in the cycle after `gnt`.
  - If `req` is still high in that cycle, it is treated as a new request.
  - Deasserting `req` before `gnt` is illegal (assertion in bench).
- Requests that rise while `buf_full`=1 wait; they are not lost.
- Round-robin: every continuously asserted request is granted within `NUM_REQ` grants.
- `rr_ptr` wraps from `NUM_REQ-1` to 0.
- Reset values: state=IDLE; `buf_wr`=0; `buf_wr_data`=0; `gnt`=0; `gnt_id`=0; `rr_ptr`=0.
- Reset mid-operation:
  - All outputs return to reset values immediately (asynchronous).
  - A write issued before reset counts as done only if `gnt` was seen.
  - The buffer is reset with the same `reset_n`.

## Timing
- Request to `buf_wr`/`gnt`: 1 cycle when IDLE and not full.
- `gnt` and `buf_wr` are coincident; both are register outputs with no combinational input-to-output paths.
- `buf_full` is used only in IDLE and WAIT.

## Configuration
- Macro: `NDS_ASYNC_BUFF_WR_ARB_LOCK_EN`.
- Defined:
  - The `req_lock` port exists.
  - If the winner's `req_lock` is high at the grant edge, the next arbitration (in IDLE) grants only that requester.
  - `rr_ptr` does not advance during the lock.
  - Other requests stall while the lock holds.
  - The lock releases at the first IDLE arbitration where the locked requester has `req`=0 or `req_lock`=0.
- Undefined:
  - The port is absent and the lock logic is not built.
  - Behaviour is plain round-robin.

## Structure
- Shared package `nds_async_buff_pkg`:
  - FSM state encoding: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2.
  - Maximum `NUM_REQ` constant (8).
- Sub-module `nds_rr_pick`: combinational round-robin picker. Inputs `req` and `rr_ptr`; outputs one-hot winner and index. Reusable by the read side.

## Test plan
- Single request: `req`=4'b0010, `buf_full`=0 → after one edge, `buf_wr`=1, `gnt`=4'b0010, `gnt_id`=1, `buf_wr_data`=word1; `buf_wr` drops after 1 cycle.
- All four requesting, buffer model draining in 2 cycles → grant order 0,1,2,3,0; no back-to-back `buf_wr`.
- `buf_full` held 1 for 10 cycles with `req`=4'b1000 → no `buf_wr`; grant 1 cycle after `buf_full` falls, in IDLE.
- `rr_ptr` wrap: last grant 3, then `req`=4'b1001 → grant 0.
- `reset_n` low during ISSUE → `buf_wr`/`gnt` 0 immediately; after release, state IDLE and `rr_ptr`=0.
- Lock (macro defined): req0 with `req_lock`=1 for 3 words while req2 is pending → grants 0,0,0, then 2.
